// File: rtl/ahb2axil.sv
`default_nettype none
// ============================================================================
// ahb2axil : AHB-Lite slave to AXI-Lite master bridge, one transfer in flight.
// Revision : 1.0
// ============================================================================
module ahb2axil #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel,
    input  logic [AWIDTH-1:0]     haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DWIDTH-1:0]     hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DWIDTH-1:0]     hrdata,
    output logic [AWIDTH-1:0]     axil_awaddr,
    output logic [2:0]            axil_awprot,
    output logic                  axil_awvalid,
    input  logic                  axil_awready,
    output logic [DWIDTH-1:0]     axil_wdata,
    output logic [DWIDTH/8-1:0]   axil_wstrb,
    output logic                  axil_wvalid,
    input  logic                  axil_wready,
    input  logic [1:0]            axil_bresp,
    input  logic                  axil_bvalid,
    output logic                  axil_bready,
    output logic [AWIDTH-1:0]     axil_araddr,
    output logic [2:0]            axil_arprot,
    output logic                  axil_arvalid,
    input  logic                  axil_arready,
    input  logic [DWIDTH-1:0]     axil_rdata,
    input  logic [1:0]            axil_rresp,
    input  logic                  axil_rvalid,
    output logic                  axil_rready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_DATA = 3'd1;
    localparam logic [2:0] WR_AXI  = 3'd2;
    localparam logic [2:0] WR_RESP = 3'd3;
    localparam logic [2:0] RD_AXI  = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;
    localparam logic [2:0] ERR1    = 3'd6;
    localparam logic [2:0] ERR2    = 3'd7;

    generate
        if (DWIDTH != 32) begin : g_bad_dwidth
            $error("ahb2axil: only DWIDTH=32 is supported");
        end
    endgenerate

    logic [2:0]          state_q,     state_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q,     hresp_d;
    logic [DWIDTH-1:0]   hrdata_q,    hrdata_d;
    logic [AWIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [DWIDTH-1:0]   wdata_q,     wdata_d;
    logic [DWIDTH/8-1:0] wstrb_q,     wstrb_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                bready_q,    bready_d;
    logic [AWIDTH-1:0]   araddr_q,    araddr_d;
    logic                arvalid_q,   arvalid_d;
    logic                rready_q,    rready_d;

    logic                w_accept;
    logic                w_legal;
    logic [DWIDTH/8-1:0] w_strb;

    assign w_accept = hsel & htrans[1] & hready;

    // Size/alignment legality and the byte lanes the transfer touches.
    always_comb begin
        w_legal = 1'b0;
        w_strb  = 4'h0;
        case (hsize)
            3'd0: begin
                w_legal = 1'b1;
                w_strb  = 4'b0001 << haddr[1:0];
            end
            3'd1: begin
                w_legal = ~haddr[0];
                w_strb  = haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                w_legal = (haddr[1:0] == 2'b00);
                w_strb  = 4'hF;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hrdata_d  = hrdata_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            IDLE, ERR2: begin
                state_d = IDLE;
                if (w_accept) begin
                    if (!w_legal) begin
                        state_d = ERR1;
                    end else if (hwrite) begin
                        state_d  = WR_DATA;
                        awaddr_d = haddr;
                        wstrb_d  = w_strb;
                    end else begin
                        state_d   = RD_AXI;
                        araddr_d  = haddr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                wdata_d   = hwdata;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                state_d   = WR_AXI;
            end
            WR_AXI: begin
                // AW and W retire independently; B is only accepted once both have.
                if (awvalid_q && axil_awready) awvalid_d = 1'b0;
                if (wvalid_q && axil_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axil_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = (axil_bresp == 2'b00) ? IDLE : ERR1;
                end
            end
            RD_AXI: begin
                if (axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (axil_rvalid) begin
                    rready_d = 1'b0;
                    hrdata_d = axil_rdata;
                    state_d  = (axil_rresp == 2'b00) ? IDLE : ERR1;
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
        hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
        hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    assign hreadyout    = hreadyout_q;
    assign hresp        = hresp_q;
    assign hrdata       = hrdata_q;
    assign axil_awaddr  = awaddr_q;
    assign axil_awprot  = 3'b000;
    assign axil_awvalid = awvalid_q;
    assign axil_wdata   = wdata_q;
    assign axil_wstrb   = wstrb_q;
    assign axil_wvalid  = wvalid_q;
    assign axil_bready  = bready_q;
    assign axil_araddr  = araddr_q;
    assign axil_arprot  = 3'b000;
    assign axil_arvalid = arvalid_q;
    assign axil_rready  = rready_q;

endmodule
`default_nettype wire
